// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: ALU operation codes, opcodes and R-type funct values.
package mips_pkg;

   // ALU operation codes (must match the ALU's own encoding)
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // Primary opcodes, instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes, instr[5:0]
   localparam logic [5:0] F_SLL = 6'h00;
   localparam logic [5:0] F_SRL = 6'h02;
   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_NOR = 6'h27;
   localparam logic [5:0] F_SLT = 6'h2A;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-execute bus: decode handshake in, registered ALU control/operands out.
// The master modport is the issue stage; the slave modport is its environment.
interface alu_issue_stage_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  id_valid;
   logic                  id_ready;
   logic [31:0]           id_instr;
   logic [DATA_W-1:0]     id_rs_data;
   logic [DATA_W-1:0]     id_rt_data;
   logic                  flush;
   logic                  ex_ready;
   logic                  ex_valid;
   logic [3:0]            aluControlOp;
   logic                  aluSrc;
   logic [DATA_W-1:0]     rsData;
   logic [DATA_W-1:0]     rtData;
   logic [4:0]            shamt;
   logic [DATA_W-1:0]     imm;
   logic [REG_ADDR_W-1:0] ex_dest;
   logic                  ex_reg_write;
   logic                  ex_mem_read;
   logic                  ex_mem_write;
   logic                  ex_branch;
   logic                  ex_illegal;
   logic [31:0]           issue_count;

   modport master (
      input  id_valid, id_instr, id_rs_data, id_rt_data, flush, ex_ready,
      output id_ready, ex_valid, aluControlOp, aluSrc, rsData, rtData, shamt, imm,
             ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal,
             issue_count
   );

   modport slave (
      output id_valid, id_instr, id_rs_data, id_rt_data, flush, ex_ready,
      input  id_ready, ex_valid, aluControlOp, aluSrc, rsData, rtData, shamt, imm,
             ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal,
             issue_count
   );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS decoder: instruction word to ALU control and writeback/memory flags.
module alu_ctrl_decode
   import mips_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [31:0]           instr,
   output logic [3:0]            op,
   output logic                  alu_src,
   output logic [REG_ADDR_W-1:0] dest,
   output logic                  reg_write,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  branch,
   output logic                  illegal
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       unused_bits;

   assign opcode      = instr[31:26];
   assign funct       = instr[5:0];
   // rs and shamt fields are routed around the decoder by the stage
   assign unused_bits = ^{instr[25:21], instr[10:6]};

   // Map opcode/funct to control; anything unrecognised is illegal and writes nothing
   always_comb begin
      op        = ALU_ADD;
      alu_src   = 1'b0;
      dest      = '0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      illegal   = 1'b0;
      unique case (opcode)
         OP_RTYPE: begin
            dest      = REG_ADDR_W'(instr[15:11]);
            reg_write = 1'b1;
            case (funct)
               F_ADD:   op = ALU_ADD;
               F_SUB:   op = ALU_SUB;
               F_AND:   op = ALU_AND;
               F_OR:    op = ALU_OR;
               F_NOR:   op = ALU_NOR;
               F_SLT:   op = ALU_SLT;
               F_SLL:   op = ALU_SLL;
               F_SRL:   op = ALU_SRL;
               default: begin
                  illegal   = 1'b1;
                  reg_write = 1'b0;
                  dest      = '0;
               end
            endcase
         end
         OP_ADDI: begin
            alu_src   = 1'b1;
            dest      = REG_ADDR_W'(instr[20:16]);
            reg_write = 1'b1;
         end
         OP_LW: begin
            alu_src   = 1'b1;
            dest      = REG_ADDR_W'(instr[20:16]);
            reg_write = 1'b1;
            mem_read  = 1'b1;
         end
         OP_SW: begin
            alu_src   = 1'b1;
            dest      = REG_ADDR_W'(instr[20:16]);
            mem_write = 1'b1;
         end
         OP_BEQ: begin
            op        = ALU_SUB;
            dest      = REG_ADDR_W'(instr[20:16]);
            branch    = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
      // Writes to $zero are discarded; this also makes the all-zero NOP harmless
      if (dest == '0) reg_write = 1'b0;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes one instruction per cycle into ALU control and
// operands, with stall/drain handshake, flush, and a saturating issue counter.
module alu_issue_stage
   import mips_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   alu_issue_stage_if.master bus
);

   logic [3:0]            dec_op;
   logic                  dec_alu_src;
   logic [REG_ADDR_W-1:0] dec_dest;
   logic                  dec_reg_write;
   logic                  dec_mem_read;
   logic                  dec_mem_write;
   logic                  dec_branch;
   logic                  dec_illegal;
   logic                  load;

   alu_ctrl_decode #(.REG_ADDR_W(REG_ADDR_W)) u_decode (
      .instr     (bus.id_instr),
      .op        (dec_op),
      .alu_src   (dec_alu_src),
      .dest      (dec_dest),
      .reg_write (dec_reg_write),
      .mem_read  (dec_mem_read),
      .mem_write (dec_mem_write),
      .branch    (dec_branch),
      .illegal   (dec_illegal)
   );

   // Accept when the register is empty or is being consumed; flush drops the incoming word
   always_comb begin
      bus.id_ready = !bus.ex_valid || bus.ex_ready;
      load         = bus.id_valid && bus.id_ready && !bus.flush;
   end

   // Issue register: reset clears everything, flush kills, load captures, drain invalidates
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ex_valid     <= 1'b0;
         bus.aluControlOp <= ALU_AND;
         bus.aluSrc       <= 1'b0;
         bus.rsData       <= '0;
         bus.rtData       <= '0;
         bus.shamt        <= '0;
         bus.imm          <= '0;
         bus.ex_dest      <= '0;
         bus.ex_reg_write <= 1'b0;
         bus.ex_mem_read  <= 1'b0;
         bus.ex_mem_write <= 1'b0;
         bus.ex_branch    <= 1'b0;
         bus.ex_illegal   <= 1'b0;
         bus.issue_count  <= '0;
      end else if (bus.flush) begin
         bus.ex_valid <= 1'b0;
      end else if (load) begin
         bus.ex_valid     <= 1'b1;
         bus.aluControlOp <= dec_op;
         bus.aluSrc       <= dec_alu_src;
         bus.rsData       <= bus.id_rs_data;
         bus.rtData       <= bus.id_rt_data;
         bus.shamt        <= bus.id_instr[10:6];
         bus.imm          <= {{(DATA_W-16){bus.id_instr[15]}}, bus.id_instr[15:0]};
         bus.ex_dest      <= dec_dest;
         bus.ex_reg_write <= dec_reg_write;
         bus.ex_mem_read  <= dec_mem_read;
         bus.ex_mem_write <= dec_mem_write;
         bus.ex_branch    <= dec_branch;
         bus.ex_illegal   <= dec_illegal;
         if (bus.issue_count != 32'hFFFF_FFFF) bus.issue_count <= bus.issue_count + 32'd1;
      end else if (bus.ex_valid && bus.ex_ready) begin
         bus.ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_alu_issue_stage;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   alu_issue_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

   alu_issue_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0]  op;
      logic        src;
      logic [4:0]  dest;
      logic        dest_chk;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
      logic        ill;
      logic [4:0]  shamt;
      logic [31:0] imm;
   } dec_t;

   // R-type table: funct -> ALU op
   logic [5:0] funct_tab [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02};
   logic [3:0] op_tab    [8] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'hC, 4'h7, 4'h4, 4'h8};
   logic [5:0] iop_tab   [4] = '{6'h08, 6'h23, 6'h2B, 6'h04};

   // Model state
   logic        m_valid;
   dec_t        m;
   logic [31:0] m_rs, m_rt;
   logic [31:0] m_count;

   function automatic dec_t ref_decode(input logic [31:0] w);
      dec_t d;
      d.op = 4'h2; d.src = 0; d.dest = 0; d.dest_chk = 0;
      d.rw = 0; d.mr = 0; d.mw = 0; d.br = 0; d.ill = 1;
      d.shamt = w[10:6];
      d.imm   = 32'(signed'(w[15:0]));
      if (w[31:26] == 6'h00) begin
         for (int i = 0; i < 8; i++)
            if (funct_tab[i] == w[5:0]) begin
               d.op = op_tab[i]; d.ill = 0; d.dest = w[15:11]; d.dest_chk = 1; d.rw = 1;
            end
      end else if (w[31:26] == 6'h08 || w[31:26] == 6'h23) begin
         d.ill = 0; d.src = 1; d.dest = w[20:16]; d.dest_chk = 1; d.rw = 1;
         d.mr = (w[31:26] == 6'h23);
      end else if (w[31:26] == 6'h2B) begin
         d.ill = 0; d.src = 1; d.mw = 1;
      end else if (w[31:26] == 6'h04) begin
         d.ill = 0; d.op = 4'h6; d.br = 1;
      end
      if (d.dest_chk && d.dest == 0) d.rw = 0;
      return d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs held across the edge
   task automatic model_edge();
      logic ld;
      ld = bus.id_valid && (!m_valid || bus.ex_ready) && !bus.flush;
      if (rst) begin
         m_valid = 0; m_rs = 0; m_rt = 0; m_count = 0;
         m = '{op: 4'h0, src: 0, dest: 0, dest_chk: 1, rw: 0, mr: 0, mw: 0,
               br: 0, ill: 0, shamt: 0, imm: 0};
      end else if (bus.flush) begin
         m_valid = 0;
      end else if (ld) begin
         m_valid = 1;
         m = ref_decode(bus.id_instr);
         m_rs = bus.id_rs_data;
         m_rt = bus.id_rt_data;
         if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      end else if (m_valid && bus.ex_ready) begin
         m_valid = 0;
      end
   endtask

   task automatic compare_all();
      chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
      chk("id_ready", 32'(bus.id_ready), 32'(!m_valid || bus.ex_ready));
      chk("issue_count", bus.issue_count, m_count);
      chk("aluControlOp", 32'(bus.aluControlOp), 32'(m.op));
      chk("aluSrc", 32'(bus.aluSrc), 32'(m.src));
      chk("rsData", bus.rsData, m_rs);
      chk("rtData", bus.rtData, m_rt);
      chk("shamt", 32'(bus.shamt), 32'(m.shamt));
      chk("imm", bus.imm, m.imm);
      chk("flags", {26'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                    bus.ex_branch, bus.ex_illegal, 1'b0},
                   {26'd0, m.rw, m.mr, m.mw, m.br, m.ill, 1'b0});
      if (m.dest_chk) chk("ex_dest", 32'(bus.ex_dest), 32'(m.dest));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] rs,
                        input logic [31:0] rt, input logic er, input logic fl);
      bus.id_valid = v; bus.id_instr = w; bus.id_rs_data = rs; bus.id_rt_data = rt;
      bus.ex_ready = er; bus.flush = fl;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 4))
         0: w[31:26] = 6'h00;
         1: begin w[31:26] = 6'h00; w[5:0] = funct_tab[$urandom_range(0, 7)]; end
         2: w[31:26] = iop_tab[$urandom_range(0, 3)];
         3: if ($urandom_range(0, 1) == 0) w = 32'h0;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      m_valid = 0; m_count = 0; m_rs = 0; m_rt = 0;
      m = ref_decode(32'h0);
      rst = 1;
      drive(0, 32'h0, 0, 0, 1, 0);
      step();
      step();
      // Reset state
      chk("rst_valid", 32'(bus.ex_valid), 0);
      chk("rst_id_ready", 32'(bus.id_ready), 1);
      chk("rst_op", 32'(bus.aluControlOp), 0);
      chk("rst_count", bus.issue_count, 0);
      rst = 0;

      // add $3,$1,$2
      drive(1, 32'h00221820, 32'd5, 32'd7, 1, 0);
      step();
      chk("add_valid", 32'(bus.ex_valid), 1);
      chk("add_op", 32'(bus.aluControlOp), 32'h2);
      chk("add_src", 32'(bus.aluSrc), 0);
      chk("add_dest", 32'(bus.ex_dest), 3);
      chk("add_rw", 32'(bus.ex_reg_write), 1);
      chk("add_rs", bus.rsData, 5);
      chk("add_rt", bus.rtData, 7);
      chk("add_count", bus.issue_count, 1);

      // addi $4,$1,-2
      drive(1, 32'h2024FFFE, 32'd1, 32'd2, 1, 0);
      step();
      chk("addi_src", 32'(bus.aluSrc), 1);
      chk("addi_imm", bus.imm, 32'hFFFF_FFFE);
      chk("addi_dest", 32'(bus.ex_dest), 4);
      chk("addi_op", 32'(bus.aluControlOp), 32'h2);

      // sll $2,$3,4
      drive(1, 32'h00031100, 32'd3, 32'd9, 1, 0);
      step();
      chk("sll_op", 32'(bus.aluControlOp), 32'h4);
      chk("sll_shamt", 32'(bus.shamt), 4);
      chk("sll_dest", 32'(bus.ex_dest), 2);

      // all-zero NOP
      drive(1, 32'h0, 0, 0, 1, 0);
      step();
      chk("nop_op", 32'(bus.aluControlOp), 32'h4);
      chk("nop_rw", 32'(bus.ex_reg_write), 0);
      chk("nop_ill", 32'(bus.ex_illegal), 0);

      // sub, then stall three cycles with `or` pending
      drive(1, 32'h00222822, 32'd11, 32'd12, 1, 0);
      step();
      chk("sub_op", 32'(bus.aluControlOp), 32'h6);
      drive(1, 32'h00223025, 32'd21, 32'd22, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_ready", 32'(bus.id_ready), 0);
         chk("stall_op", 32'(bus.aluControlOp), 32'h6);
         chk("stall_rs", bus.rsData, 11);
      end
      bus.ex_ready = 1;
      #1;
      chk("release_ready", 32'(bus.id_ready), 1);
      step();
      chk("or_op", 32'(bus.aluControlOp), 32'h1);
      chk("or_count", bus.issue_count, 6);

      // flush collides with lw: dropped, not counted
      drive(1, 32'h8C220004, 32'd1, 32'd2, 1, 1);
      step();
      chk("flush_valid", 32'(bus.ex_valid), 0);
      chk("flush_count", bus.issue_count, 6);

      // illegal opcode 0x3F
      drive(1, 32'hFC221800, 32'd1, 32'd2, 1, 0);
      step();
      chk("ill_flag", 32'(bus.ex_illegal), 1);
      chk("ill_rw", 32'(bus.ex_reg_write), 0);
      chk("ill_count", bus.issue_count, 7);

      // reset in the middle of a stall
      drive(1, 32'h00221820, 32'd5, 32'd7, 0, 0);
      step();
      drive(0, 32'h0, 0, 0, 0, 0);
      step();
      chk("pre_rst_valid", 32'(bus.ex_valid), 1);
      rst = 1;
      step();
      rst = 0;
      chk("midrst_valid", 32'(bus.ex_valid), 0);
      chk("midrst_count", bus.issue_count, 0);
      chk("midrst_ready", 32'(bus.id_ready), 1);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
               $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
